// File: rtl/proc_pkg.sv
// Shared core constants for the fetch front end.
// Also holds the counter-width helper used by the prefetch buffer and its credit logic.
package proc_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = '0;

    // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pf_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO with registered head (no bypass).
// clear empties the buffer in one cycle and takes priority over push/pop.
module pf_fifo
    import proc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int CW   = cnt_w(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          clear,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // The credit scheme upstream must keep these from ever firing.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !clear && count_q == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && !clear && count_q == '0));

endmodule

// File: rtl/instr_prefetch.sv
// Instruction fetch front end: sequential PC generation, in-order memory requests,
// prefetch buffering and redirect flush with discard of stale in-flight responses.
module instr_prefetch
    import proc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ADDR_W,
    parameter int DW    = INSTR_W,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rsp_valid,
    input  logic [DW-1:0] imem_rsp_data,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          rsp_err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready. Responses carry no ready and are always taken.

    localparam int CW = cnt_w(DEPTH);
    localparam logic [AW-1:0] STEP = AW'(PC_STEP);

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic          rsp_err_q, rsp_err_d;

    logic [CW-1:0]    fifo_count;
    logic [AW+DW-1:0] fifo_head;
    logic             issue_ok, req_fire;
    logic             rsp_ok, rsp_spurious, push, pop;

    // Buffered plus in-flight words never exceed DEPTH, so a push always finds room.
    assign issue_ok       = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
    assign imem_req_valid = issue_ok & ~redirect & ~reset;
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_ok       = imem_rsp_valid & (outstanding_q != '0);
    assign rsp_spurious = imem_rsp_valid & (outstanding_q == '0);
    assign push         = rsp_ok & (drop_cnt_q == '0) & ~redirect;

    assign instr_valid = (fifo_count != '0) & ~redirect;
    assign pop         = instr_valid & instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        rsp_err_d     = rsp_err_q | rsp_spurious;

        if (req_fire && !rsp_ok)      outstanding_d = outstanding_q + CW'(1);
        else if (!req_fire && rsp_ok) outstanding_d = outstanding_q - CW'(1);

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            // Every request still in flight now belongs to the old path; the words
            // already marked for discard are part of that same outstanding total.
            drop_cnt_d = outstanding_q - CW'(rsp_ok);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
            if (rsp_ok) begin
                if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
                else                  rsp_pc_d   = rsp_pc_q + STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    pf_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .pop       (pop),
        .clear     (redirect),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign instr    = fifo_head[DW-1:0];
    assign instr_pc = fifo_head[AW+DW-1:DW];
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: in-order memory responder with programmable latency and an
// epoch-tagged reference model of the delivered instruction stream.
module tb_instr_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        rsp_err;

    always #5 clk = ~clk;

    instr_prefetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .rsp_err        (rsp_err)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } inf_t;

    inf_t        inf_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] pop_q[$];
    logic [31:0] m_fetch_pc;
    logic        m_err;
    int          epoch, cyc, last_due;
    int          lat_min, lat_max;
    logic        spur;
    int          n_tests, n_fail;
    int          dut_acc;
    logic        obs_v, obs_pop;
    logic [31:0] obs_pc, obs_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], ~a[15:8], a[23:16], a[31:24]} ^ 32'h3C96_A50F;
    endfunction

    // One clock cycle: present memory response, compare outputs with the model,
    // advance the model, cross the rising edge, return at the next falling edge.
    task automatic step();
        logic        exp_req, exp_iv;
        inf_t        it;
        int          lat;
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (inf_q.size() != 0 && inf_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(inf_q[0].addr);
        end else if (spur && inf_q.size() == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_req = (exp_q.size() + inf_q.size() < DEPTH) && !redirect;
        exp_iv  = (exp_q.size() != 0) && !redirect;

        n_tests++;
        if (imem_req_valid !== exp_req) begin
            n_fail++;
            $display("FAIL req_valid cyc %0d: got %0b want %0b", cyc, imem_req_valid, exp_req);
        end
        if (exp_req) begin
            n_tests++;
            if (imem_addr !== m_fetch_pc) begin
                n_fail++;
                $display("FAIL imem_addr cyc %0d: got %h want %h", cyc, imem_addr, m_fetch_pc);
            end
        end
        n_tests++;
        if (instr_valid !== exp_iv) begin
            n_fail++;
            $display("FAIL instr_valid cyc %0d: got %0b want %0b", cyc, instr_valid, exp_iv);
        end
        if (exp_iv) begin
            n_tests++;
            if ({instr_pc, instr} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL head cyc %0d: got %h/%h want %h/%h", cyc, instr_pc, instr,
                         exp_q[0][63:32], exp_q[0][31:0]);
            end
        end
        n_tests++;
        if (rsp_err !== m_err) begin
            n_fail++;
            $display("FAIL rsp_err cyc %0d: got %0b want %0b", cyc, rsp_err, m_err);
        end

        obs_v    = instr_valid;
        obs_pop  = instr_valid && instr_ready;
        obs_pc   = instr_pc;
        obs_data = instr;
        if (imem_req_valid && imem_req_ready) dut_acc++;

        if (exp_iv && instr_ready) void'(exp_q.pop_front());
        if (redirect) begin
            epoch++;
            exp_q.delete();
            m_fetch_pc = redirect_pc;
        end
        if (imem_rsp_valid) begin
            if (inf_q.size() == 0) begin
                m_err = 1'b1;
            end else begin
                it = inf_q.pop_front();
                if (it.epoch == epoch) exp_q.push_back({it.addr, mem_word(it.addr)});
            end
        end
        if (exp_req && imem_req_ready) begin
            lat = $urandom_range(lat_max, lat_min);
            it.addr  = m_fetch_pc;
            it.epoch = epoch;
            it.due   = cyc + lat;
            if (it.due <= last_due) it.due = last_due + 1;
            last_due = it.due;
            inf_q.push_back(it);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic model_clear();
        exp_q.delete();
        inf_q.delete();
        m_fetch_pc = 32'h0;
        m_err      = 1'b0;
        epoch++;
        last_due   = cyc;
    endtask

    task automatic collect(input int n, input int max_cycles);
        pop_q.delete();
        for (int i = 0; i < max_cycles && pop_q.size() < n; i++) begin
            step();
            if (obs_pop) pop_q.push_back({obs_pc, obs_data});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; spur = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; redirect_pc = '0; spur = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({imem_req_valid, instr_valid, rsp_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 000", {imem_req_valid, instr_valid, rsp_err});
        end
        n_tests++;
        if (imem_addr !== 32'h0 || dut.fifo_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got addr %h count %0d want 0/0", imem_addr, dut.fifo_count);
        end
        model_clear();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        lat_min = 1; lat_max = 1; instr_ready = 1'b1; imem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if (i < 2) begin
                if (obs_v !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_lat cyc %0d: got valid %0b want 0", i, obs_v);
                end
            end else if (obs_v !== 1'b1 || obs_pc !== 32'(4*(i-2)) || obs_data !== mem_word(obs_pc)) begin
                n_fail++;
                $display("FAIL stream cyc %0d: got %0b pc %h data %h want 1 pc %h", i, obs_v,
                         obs_pc, obs_data, 32'(4*(i-2)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_min = 1; lat_max = 1; instr_ready = 1'b0; imem_req_ready = 1'b1;
        dut_acc = 0;
        repeat (10) step();
        n_tests++;
        if (dut_acc !== 4 || imem_req_valid !== 1'b0 || dut.fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL bp_hold: got acc %0d req %0b count %0d want 4/0/4", dut_acc,
                     imem_req_valid, dut.fifo_count);
        end
        instr_ready = 1'b1;
        collect(10, 20);
        n_tests++;
        if (pop_q.size() != 10) begin
            n_fail++;
            $display("FAIL bp_count: got %0d pops want 10", pop_q.size());
        end
        for (int k = 0; k < pop_q.size(); k++) begin
            n_tests++;
            if (pop_q[k][63:32] !== 32'(4*k)) begin
                n_fail++;
                $display("FAIL bp_seq %0d: got pc %h want %h", k, pop_q[k][63:32], 32'(4*k));
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        lat_min = 4; lat_max = 4; instr_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        n_tests++;
        if (dut.drop_cnt_q !== 3'd3) begin
            n_fail++;
            $display("FAIL rd_drop: got %0d want 3", dut.drop_cnt_q);
        end
        collect(2, 30);
        n_tests++;
        if (pop_q.size() != 2 || pop_q[0] !== {32'h100, mem_word(32'h100)} ||
            pop_q[1][63:32] !== 32'h104) begin
            n_fail++;
            $display("FAIL rd_first: got %0d pops want pc 100,104", pop_q.size());
        end
    endtask

    task automatic test_redirect_collide();
        int exp_drop;
        do_reset();
        lat_min = 2; lat_max = 2; instr_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (8) step();
        exp_drop = inf_q.size() - ((inf_q.size() != 0 && inf_q[0].due <= cyc) ? 1 : 0);
        redirect = 1'b1; redirect_pc = 32'h2000;
        step();
        redirect = 1'b0;
        n_tests++;
        if (obs_v !== 1'b0 || dut.fifo_count !== '0 || dut.drop_cnt_q !== 3'(exp_drop)) begin
            n_fail++;
            $display("FAIL coll: got valid %0b count %0d drop %0d want 0/0/%0d", obs_v,
                     dut.fifo_count, dut.drop_cnt_q, exp_drop);
        end
        step();
        n_tests++;
        if (obs_v !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_after: got valid %0b want 0", obs_v);
        end
        collect(1, 20);
        n_tests++;
        if (pop_q.size() != 1 || pop_q[0][63:32] !== 32'h2000) begin
            n_fail++;
            $display("FAIL coll_next: got %0d pops want pc 2000", pop_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat_min = 3; lat_max = 3; instr_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (6) step();
        redirect = 1'b1; redirect_pc = 32'h3000;
        step();
        redirect_pc = 32'h5000;
        step();
        redirect = 1'b0;
        collect(3, 30);
        n_tests++;
        if (pop_q.size() != 3 || pop_q[0][63:32] !== 32'h5000 || pop_q[2][63:32] !== 32'h5008) begin
            n_fail++;
            $display("FAIL b2b: got %0d pops want pc 5000..5008", pop_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat_min = 1; lat_max = 1; instr_ready = 1'b1; imem_req_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        collect(4, 20);
        n_tests++;
        if (pop_q.size() != 4 || pop_q[1][63:32] !== 32'hFFFF_FFFC || pop_q[2][63:32] !== 32'h0 ||
            pop_q[3] !== {32'h4, mem_word(32'h4)}) begin
            n_fail++;
            $display("FAIL wrap: got %0d pops want pc fffffff8,fffffffc,0,4", pop_q.size());
        end
    endtask

    task automatic test_spurious_and_reset();
        do_reset();
        lat_min = 1; lat_max = 1; instr_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (8) step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        n_tests++;
        if (rsp_err !== 1'b1 || dut.fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL spur: got err %0b count %0d want 1/4", rsp_err, dut.fifo_count);
        end
        repeat (3) step();
        instr_ready = 1'b1;
        collect(4, 10);
        n_tests++;
        if (rsp_err !== 1'b1 || pop_q.size() != 4 || pop_q[3][63:32] !== 32'hC) begin
            n_fail++;
            $display("FAIL spur_after: got err %0b pops %0d want 1/4", rsp_err, pop_q.size());
        end
        #2 reset = 1'b1;
        imem_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if ({imem_req_valid, instr_valid, rsp_err} !== 3'b000 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst: got %b addr %h want 000 addr 0",
                     {imem_req_valid, instr_valid, rsp_err}, imem_addr);
        end
        @(negedge clk);
        model_clear();
        reset = 1'b0;
        collect(2, 10);
        n_tests++;
        if (pop_q.size() != 2 || pop_q[0][63:32] !== 32'h0 || pop_q[1][63:32] !== 32'h4) begin
            n_fail++;
            $display("FAIL rst_restart: got %0d pops want pc 0,4", pop_q.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            instr_ready    = $urandom_range(0, 3) != 0;
            imem_req_ready = $urandom_range(0, 3) != 0;
            redirect       = $urandom_range(0, 24) == 0;
            r              = $urandom;
            redirect_pc    = {r[31:2], 2'b00};
            step();
        end
        redirect = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b0;
        repeat (12) step();
        n_tests++;
        if (dut.fifo_count !== 3'(exp_q.size()) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: got count %0d want %0d", dut.fifo_count, exp_q.size());
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; dut_acc = 0;
        lat_min = 1; lat_max = 1;
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; spur = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collide();
        test_back_to_back();
        test_wrap();
        test_spurious_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
